// File: rtl/pd_fetch_queue.sv
// pd_fetch_queue: fetch front-end for the pipelined core.
//
// Issues sequential word fetches to a latency-tolerant imem port and buffers
// the returned words with their PCs in a DEPTH-entry FIFO. Decode consumes the
// FIFO head over a valid/ready stream. A redirect from execute flushes the
// FIFO, retargets fetch and marks every in-flight response as stale.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/ready/addr  imem request channel (word-aligned address)
//   resp_valid/data       imem response, in order, at most one per cycle
//   out_valid/ready       decode stream handshake (out_ready low = stall)
//   out_pc, out_instr     head entry, driven straight from storage registers
//   redirect_valid/pc     flush and new fetch target (pc[1:0] ignored)
//   outstanding           requests currently in flight (debug)
//
// Optional build macro FETCH_PERF_EN adds saturating 32-bit counters
// perf_empty_cycles, perf_redirects and perf_dropped.

module pd_fetch_queue #(
  parameter int unsigned      DATAW           = 32,
  parameter logic [DATAW-1:0] BASE_ADDR       = 32'h0100_0000,
  parameter int unsigned      DEPTH           = 4,
  parameter int unsigned      MAX_OUTSTANDING = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic [DATAW-1:0]                   req_addr,
  input  logic                               resp_valid,
  input  logic [DATAW-1:0]                   resp_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATAW-1:0]                   out_pc,
  output logic [DATAW-1:0]                   out_instr,
  input  logic                               redirect_valid,
  input  logic [DATAW-1:0]                   redirect_pc,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                        perf_empty_cycles,
  output logic [31:0]                        perf_redirects,
  output logic [31:0]                        perf_dropped
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [DATAW-1:0]            fetch_pc_q, fetch_pc_d;
  logic [DATAW-1:0]            resp_pc_q, resp_pc_d;
  logic [CW-1:0]               count_q, count_d;
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]               outst_q, outst_d;
  logic [OW-1:0]               drop_q, drop_d;
  logic [DEPTH-1:0][DATAW-1:0] pc_mem_q, instr_mem_q;

  logic             rsp_ok, issue, push, pop;
  logic [DATAW-1:0] redir_pc;
  logic             unused_redir_lsb;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_ok           = resp_valid && (outst_q != '0);
  assign redir_pc         = {redirect_pc[DATAW-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Credit rule: never have more words promised than free FIFO slots, so a
  // returning word always has somewhere to land.
  assign req_valid = !reset && !redirect_valid &&
                     ((32'(count_q) + 32'(outst_q)) < DEPTH) &&
                     (32'(outst_q) < MAX_OUTSTANDING);
  assign req_addr  = fetch_pc_q;
  assign issue     = req_valid && req_ready;

  assign out_valid = !reset && (count_q != '0);
  assign out_pc    = pc_mem_q[rptr_q];
  assign out_instr = instr_mem_q[rptr_q];
  assign pop       = out_valid && out_ready;

  // Words still owed from before the last redirect are stale.
  assign push = rsp_ok && !redirect_valid && (drop_q == '0);

  assign outstanding = outst_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    drop_d     = drop_q;
    // issue is forced low during a redirect, so this holds in both branches
    outst_d    = outst_q + OW'(issue) - OW'(rsp_ok);
    if (redirect_valid) begin
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      // a word returning this very cycle is already accounted for
      drop_d     = outst_q - OW'(rsp_ok);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + DATAW'(4);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (push) begin
        wptr_d    = wptr_q + PW'(1);
        resp_pc_d = resp_pc_q + DATAW'(4);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= BASE_ADDR;
      resp_pc_q  <= BASE_ADDR;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      pc_mem_q[wptr_q]    <= resp_pc_q;
      instr_mem_q[wptr_q] <= resp_data;
    end
  end

  // Stale returns during reset are expected and not flagged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(resp_valid && (outst_q == '0)));
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_empty_q, perf_redir_q, perf_drop_q;
  logic        dropped;

  assign dropped = rsp_ok && !push;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_empty_q <= '0;
      perf_redir_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (!out_valid && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
      if (redirect_valid && (perf_redir_q != '1)) perf_redir_q <= perf_redir_q + 32'd1;
      if (dropped && (perf_drop_q != '1)) perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_redirects    = perf_redir_q;
  assign perf_dropped      = perf_drop_q;
`endif

endmodule

// File: tb/tb_pd_fetch_queue.sv
// Bench for pd_fetch_queue: an imem model with programmable latency plus a
// scoreboard of {pc, instr} words that decode should see, tagged by fetch
// epoch so that words fetched before a redirect are known to be stale.
module tb_pd_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clock = 1'b0, reset = 1'b1;
  logic        req_ready = 1'b1, resp_valid = 1'b0, out_ready = 1'b1, redirect_valid = 1'b0;
  logic [31:0] resp_data = '0, redirect_pc = '0;
  logic        req_valid, out_valid;
  logic [31:0] req_addr, out_pc, out_instr;
  logic [1:0]  outstanding;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_empty_cycles, perf_redirects, perf_dropped;
`endif

  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  pd_fetch_queue #(.DATAW(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .outstanding(outstanding)
`ifdef FETCH_PERF_EN
    , .perf_empty_cycles(perf_empty_cycles), .perf_redirects(perf_redirects),
    .perf_dropped(perf_dropped)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- imem model + scoreboard ----------------
  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  pend_t       mq[$];
  ent_t        exp_q[$];
  int          cyc = 0, epoch = 0, m_outst = 0, lat = 1, jit = 0, last_due = 0;
  int          sz, os, d_due, r_epoch = 0;
  bit          iss, pp;
  logic [31:0] m_fetch = BASE, r_addr = '0;
  logic [31:0] m_perf_e = '0, m_perf_r = '0, m_perf_d = '0;

  always begin
    @(posedge clock);
    cyc++;
    sz = exp_q.size();
    os = m_outst;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_outst  = 0;
      m_fetch  = BASE;
      epoch++;
      m_perf_e = '0; m_perf_r = '0; m_perf_d = '0;
    end else begin
      iss = !redirect_valid && (sz + os < DEPTH) && (os < MAXO) && req_ready;
      pp  = (sz != 0) && out_ready;
      if (sz == 0) m_perf_e++;
      if (pp) void'(exp_q.pop_front());
      if (resp_valid) begin
        m_outst--;
        if (redirect_valid || r_epoch != epoch) m_perf_d++;
        else exp_q.push_back(ent_t'{pc: r_addr, instr: word(r_addr)});
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_perf_r++;
      end else if (iss) begin
        d_due = cyc - 1 + lat + ((jit > 0) ? int'($urandom_range(0, jit)) : 0);
        if (d_due <= last_due) d_due = last_due + 1;
        last_due = d_due;
        mq.push_back(pend_t'{addr: m_fetch, epoch: epoch, due: d_due});
        m_outst++;
        m_fetch += 32'd4;
      end
    end
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      resp_valid = 1'b1;
      r_addr     = mq[0].addr;
      r_epoch    = mq[0].epoch;
      resp_data  = word(r_addr);
      void'(mq.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    lat = 1; jit = 0; out_ready = 1'b1; req_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset req_valid: got %b want 0", req_valid); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (outstanding !== 2'd0) begin n_bad++; $display("FAIL reset outstanding: got %0d want 0", outstanding); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== BASE)
      begin n_bad++; $display("FAIL first_req: got v=%b addr=%h want v=1 addr=%h", req_valid, req_addr, BASE); end
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || req_addr !== BASE + 32'd4)
      begin n_bad++; $display("FAIL second_req: got ov=%b addr=%h want ov=0 addr=%h", out_valid, req_addr, BASE + 32'd4); end
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== BASE || out_instr !== word(BASE))
      begin n_bad++; $display("FAIL first_out: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", out_valid, out_pc, out_instr, BASE, word(BASE)); end
  endtask

  task automatic test_stream();
    bit ev;
    lat = 1; jit = 0; out_ready = 1'b1; req_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      ev = !reset && !redirect_valid && (exp_q.size() + m_outst < DEPTH) && (m_outst < MAXO);
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0))
        begin n_bad++; $display("FAIL stream out_valid: got %b want %b cyc %0d", out_valid, exp_q.size() != 0, cyc); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr)
          begin n_bad++; $display("FAIL stream head: got %h/%h want %h/%h", out_pc, out_instr, exp_q[0].pc, exp_q[0].instr); end
      end
      n_cmp++;
      if (req_valid !== ev) begin n_bad++; $display("FAIL stream req_valid: got %b want %b cyc %0d", req_valid, ev, cyc); end
      n_cmp++;
      if (req_addr !== m_fetch) begin n_bad++; $display("FAIL stream req_addr: got %h want %h", req_addr, m_fetch); end
      n_cmp++;
      if ({30'd0, outstanding} !== 32'(m_outst))
        begin n_bad++; $display("FAIL stream outstanding: got %0d want %0d", outstanding, m_outst); end
    end
  endtask

  task automatic test_fill();
    int iss_n = 0, k = 0;
    bit seen = 0;
    lat = 1; jit = 0; req_ready = 1'b1; out_ready = 1'b0;
    do_reset(2);
    repeat (12) begin
      #1;
      if (req_valid && req_ready) iss_n++;
      @(negedge clock);
    end
    n_cmp++;
    if (iss_n != DEPTH) begin n_bad++; $display("FAIL fill issued: got %0d want %0d", iss_n, DEPTH); end
    n_cmp++;
    if (req_valid !== 1'b0 || out_valid !== 1'b1 || outstanding !== 2'd0)
      begin n_bad++; $display("FAIL fill state: got rv=%b ov=%b os=%0d want rv=0 ov=1 os=0", req_valid, out_valid, outstanding); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || !seen); c++) begin
      #1;
      if (out_valid && out_ready && k < 4) begin
        n_cmp++;
        if (out_pc !== BASE + 32'(4 * k))
          begin n_bad++; $display("FAIL drain order: got %h want %h", out_pc, BASE + 32'(4 * k)); end
        k++;
      end
      if (req_valid && !seen) begin
        seen = 1;
        n_cmp++;
        if (req_addr !== BASE + 32'h10) begin n_bad++; $display("FAIL fill resume: got %h want %h", req_addr, BASE + 32'h10); end
      end
      @(negedge clock);
    end
    n_cmp++;
    if (k != 4 || !seen) begin n_bad++; $display("FAIL drain timeout: got pops=%0d resumed=%0d want 4/1", k, seen); end
  endtask

  task automatic test_full_push_pop();
    int got = 0;
    logic [31:0] pc = BASE;
    lat = 3; jit = 0; req_ready = 1'b1; out_ready = 1'b1;
    do_reset(2);
    for (int c = 0; c < 800 && got < 100; c++) begin
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_pc !== pc || out_instr !== word(pc))
          begin n_bad++; $display("FAIL pp word %0d: got %h/%h want %h/%h", got, out_pc, out_instr, pc, word(pc)); end
        pc += 32'd4;
        got++;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (got != 100) begin n_bad++; $display("FAIL pp count: got %0d want 100", got); end
  endtask

  task automatic test_redirect();
    int c;
    lat = 3; jit = 0; req_ready = 1'b1; out_ready = 1'b1;
    do_reset(2);
    for (c = 0; c < 20 && outstanding != 2'd2; c++) @(negedge clock);
    n_cmp++;
    if (outstanding !== 2'd2) begin n_bad++; $display("FAIL redir setup: got os=%0d want 2", outstanding); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0103;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin n_bad++; $display("FAIL redir req_valid: got %b want 0", req_valid); end
    @(negedge clock);
    redirect_valid = 1'b0;
    for (c = 0; c < 30 && !out_valid; c++) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0100_0100 || out_instr !== word(32'h0100_0100))
      begin n_bad++; $display("FAIL redir target: got v=%b pc=%h ins=%h want v=1 pc=01000100 ins=%h", out_valid, out_pc, out_instr, word(32'h0100_0100)); end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_dropped !== 32'd2) begin n_bad++; $display("FAIL perf_dropped: got %0d want 2", perf_dropped); end
    n_cmp++;
    if (perf_redirects !== 32'd1) begin n_bad++; $display("FAIL perf_redirects: got %0d want 1", perf_redirects); end
    n_cmp++;
    if (perf_empty_cycles !== m_perf_e) begin n_bad++; $display("FAIL perf_empty: got %0d want %0d", perf_empty_cycles, m_perf_e); end
`endif
    // back-to-back redirects: only the second target may surface
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0200_0010;
    @(negedge clock);
    redirect_pc    = 32'h0300_0021;
    @(negedge clock);
    redirect_valid = 1'b0;
    for (c = 0; c < 30 && !out_valid; c++) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0300_0020)
      begin n_bad++; $display("FAIL b2b redirect: got v=%b pc=%h want v=1 pc=03000020", out_valid, out_pc); end
    @(negedge clock);
    for (c = 0; c < 10 && !out_valid; c++) @(negedge clock);
    n_cmp++;
    if (out_pc !== 32'h0300_0024) begin n_bad++; $display("FAIL b2b next: got %h want 03000024", out_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_dropped !== m_perf_d || perf_redirects !== 32'd3)
      begin n_bad++; $display("FAIL b2b perf: got d=%0d r=%0d want d=%0d r=3", perf_dropped, perf_redirects, m_perf_d); end
`endif
  endtask

  task automatic test_reset_mid();
    int c;
    lat = 3; jit = 0; req_ready = 1'b1; out_ready = 1'b0;
    do_reset(2);
    for (c = 0; c < 40 && !(exp_q.size() + m_outst == DEPTH && m_outst >= 1); c++) @(negedge clock);
    n_cmp++;
    if (!(exp_q.size() + m_outst == DEPTH && m_outst >= 1))
      begin n_bad++; $display("FAIL midrst setup: got count=%0d os=%0d want sum %0d", exp_q.size(), m_outst, DEPTH); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || req_valid !== 1'b0)
      begin n_bad++; $display("FAIL midrst during: got ov=%b rv=%b want 0/0", out_valid, req_valid); end
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || outstanding !== 2'd0)
      begin n_bad++; $display("FAIL midrst after: got ov=%b os=%0d want 0/0", out_valid, outstanding); end
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== BASE)
      begin n_bad++; $display("FAIL midrst restart: got v=%b addr=%h want 1/%h", req_valid, req_addr, BASE); end
    out_ready = 1'b1;
    for (c = 0; c < 20 && !out_valid; c++) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== BASE || out_instr !== word(BASE))
      begin n_bad++; $display("FAIL midrst first: got v=%b pc=%h ins=%h want 1/%h/%h", out_valid, out_pc, out_instr, BASE, word(BASE)); end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    int k = 0, p = 0;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    lat = 1; jit = 0; req_ready = 1'b1; out_ready = 1'b1;
    do_reset(2);
    repeat (3) @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clock);
    redirect_valid = 1'b0;
    for (int c = 0; c < 15 && (k < 3 || p < 3); c++) begin
      #1;
      if (req_valid && req_ready && k < 3) begin
        n_cmp++;
        if (req_addr !== wexp[k]) begin n_bad++; $display("FAIL wrap req %0d: got %h want %h", k, req_addr, wexp[k]); end
        k++;
      end
      if (out_valid && out_ready && p < 3) begin
        n_cmp++;
        if (out_pc !== wexp[p] || out_instr !== word(wexp[p]))
          begin n_bad++; $display("FAIL wrap out %0d: got %h want %h", p, out_pc, wexp[p]); end
        p++;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (k != 3 || p != 3) begin n_bad++; $display("FAIL wrap timeout: got req=%0d out=%0d want 3/3", k, p); end
  endtask

  task automatic test_random();
    bit ev;
    jit = 2; lat = int'($urandom_range(1, 4));
    req_ready = 1'b1; out_ready = 1'b1;
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      ev = !reset && !redirect_valid && (exp_q.size() + m_outst < DEPTH) && (m_outst < MAXO);
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0))
        begin n_bad++; $display("FAIL rand out_valid: got %b want %b cyc %0d", out_valid, exp_q.size() != 0, cyc); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr)
          begin n_bad++; $display("FAIL rand head: got %h/%h want %h/%h cyc %0d", out_pc, out_instr, exp_q[0].pc, exp_q[0].instr, cyc); end
      end
      n_cmp++;
      if (req_valid !== ev) begin n_bad++; $display("FAIL rand req_valid: got %b want %b cyc %0d", req_valid, ev, cyc); end
      if (ev) begin
        n_cmp++;
        if (req_addr !== m_fetch) begin n_bad++; $display("FAIL rand req_addr: got %h want %h", req_addr, m_fetch); end
      end
      n_cmp++;
      if ({30'd0, outstanding} !== 32'(m_outst))
        begin n_bad++; $display("FAIL rand outstanding: got %0d want %0d cyc %0d", outstanding, m_outst, cyc); end
`ifdef FETCH_PERF_EN
      n_cmp++;
      if (perf_empty_cycles !== m_perf_e || perf_redirects !== m_perf_r || perf_dropped !== m_perf_d)
        begin n_bad++; $display("FAIL rand perf: got %0d/%0d/%0d want %0d/%0d/%0d", perf_empty_cycles, perf_redirects, perf_dropped, m_perf_e, m_perf_r, m_perf_d); end
`endif
      out_ready      = ($urandom_range(0, 3) != 0);
      req_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = BASE + 32'($urandom_range(0, 4095));
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_full_push_pop();
    test_redirect();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
